// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves JAL/JALR/branches, flags mispredicts, trains a bimodal predictor
module branch_resolve_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [XLEN-1:0]  fetch_pc_in,
  output logic             predict_taken_out,
  input  logic             valid_in,
  input  logic             flush_in,
  input  logic [XLEN-1:0]  pc_in,
  input  logic [XLEN-1:0]  rs1_in,
  input  logic [XLEN-1:0]  rs2_in,
  input  logic [XLEN-1:0]  imm_in,
  input  logic [4:0]       opcode_6_to_2_in,
  input  logic [2:0]       funct3_in,
  input  logic             predicted_taken_in,
  output logic             resolve_valid_out,
  output logic             branch_taken_out,
  output logic             mispredict_out,
  output logic [XLEN-1:0]  redirect_pc_out,
  output logic [XLEN-1:0]  link_addr_out,
  output logic             misaligned_out,
  output logic [CNT_W-1:0] branch_count_out,
  output logic [CNT_W-1:0] mispredict_count_out
);
  localparam int IDX = $clog2(BHT_ENTRIES);
  logic [1:0] bht [BHT_ENTRIES];
  logic is_jal, is_jalr, is_br, acc, cond, taken, mis_al, mp, upd;
  logic [XLEN-1:0] jalr_sum, target, pc4;
  logic [IDX-1:0] widx;
  logic [1:0] cur, nxt;
  logic unused_bits;
  assign unused_bits = ^{fetch_pc_in[XLEN-1:IDX+2], fetch_pc_in[1:0], jalr_sum[0]};
  assign predict_taken_out = bht[fetch_pc_in[IDX+1:2]][1];
  always_comb begin
    is_jal   = opcode_6_to_2_in == 5'b11011;
    is_jalr  = opcode_6_to_2_in == 5'b11001;
    is_br    = opcode_6_to_2_in == 5'b11000;
    acc      = valid_in & ~flush_in & (is_jal | is_jalr | is_br);
    cond     = funct3_in[2:1] == 2'b00 ? rs1_in == rs2_in :
               funct3_in[2:1] == 2'b10 ? $signed(rs1_in) < $signed(rs2_in) :
               funct3_in[2:1] == 2'b11 ? rs1_in < rs2_in : 1'b0;
    taken    = is_br ? (funct3_in[2:1] != 2'b01) & (cond ^ funct3_in[0]) : 1'b1;
    jalr_sum = rs1_in + imm_in;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : pc_in + imm_in;
    pc4      = pc_in + XLEN'(4);
    mis_al   = taken & target[1];
    mp       = ~mis_al & (is_jalr | (is_jal & ~predicted_taken_in) | (is_br & (predicted_taken_in != taken)));
    upd      = acc & is_br & ~mis_al;
    widx     = pc_in[IDX+1:2];
    cur      = bht[widx];
    nxt      = taken ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      resolve_valid_out    <= 1'b0;
      branch_taken_out     <= 1'b0;
      mispredict_out       <= 1'b0;
      redirect_pc_out      <= '0;
      link_addr_out        <= '0;
      misaligned_out       <= 1'b0;
      branch_count_out     <= '0;
      mispredict_count_out <= '0;
    end else begin
      resolve_valid_out <= acc;
      if (acc) begin
        branch_taken_out     <= taken;
        mispredict_out       <= mp;
        redirect_pc_out      <= taken ? target : pc4;
        link_addr_out        <= pc4;
        misaligned_out       <= mis_al;
        branch_count_out     <= branch_count_out + CNT_W'(1);
        mispredict_count_out <= mispredict_count_out + CNT_W'(mp);
      end
      if (upd) bht[widx] <= nxt;
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: vector table, corner sequences and random stimulus against a reference model
module tb_branch_resolve_unit;
  localparam logic [4:0] JAL = 5'b11011, JALR = 5'b11001, BR = 5'b11000;
  logic clk_in = 1'b0, rst_n_in = 1'b0;
  logic [31:0] fetch_pc_in = '0, pc_in = '0, rs1_in = '0, rs2_in = '0, imm_in = '0;
  logic valid_in = 1'b0, flush_in = 1'b0, predicted_taken_in = 1'b0;
  logic [4:0] opcode_6_to_2_in = '0;
  logic [2:0] funct3_in = '0;
  logic predict_taken_out, resolve_valid_out, branch_taken_out, mispredict_out, misaligned_out;
  logic [31:0] redirect_pc_out, link_addr_out, branch_count_out, mispredict_count_out;
  logic p4, rv4, tk4, mp4, mis4;
  logic [31:0] rd4, lk4;
  logic [3:0] bc4, mc4;
  branch_resolve_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .fetch_pc_in(fetch_pc_in), .predict_taken_out(predict_taken_out),
    .valid_in(valid_in), .flush_in(flush_in), .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .predicted_taken_in(predicted_taken_in),
    .resolve_valid_out(resolve_valid_out), .branch_taken_out(branch_taken_out), .mispredict_out(mispredict_out),
    .redirect_pc_out(redirect_pc_out), .link_addr_out(link_addr_out), .misaligned_out(misaligned_out),
    .branch_count_out(branch_count_out), .mispredict_count_out(mispredict_count_out));
  branch_resolve_unit #(.CNT_W(4)) dut4 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .fetch_pc_in(fetch_pc_in), .predict_taken_out(p4),
    .valid_in(valid_in), .flush_in(flush_in), .pc_in(pc_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
    .opcode_6_to_2_in(opcode_6_to_2_in), .funct3_in(funct3_in), .predicted_taken_in(predicted_taken_in),
    .resolve_valid_out(rv4), .branch_taken_out(tk4), .mispredict_out(mp4),
    .redirect_pc_out(rd4), .link_addr_out(lk4), .misaligned_out(mis4),
    .branch_count_out(bc4), .mispredict_count_out(mc4));
  always #5 clk_in = ~clk_in;
  int n_cmp = 0, n_bad = 0;
  int bht[64];
  bit m_rv, m_tk, m_mp, m_mis;
  logic [31:0] m_redir, m_link;
  longint m_bc, m_mc;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    foreach (bht[i]) bht[i] = 1;
    {m_rv, m_tk, m_mp, m_mis} = '0;
    m_redir = '0;
    m_link = '0;
    m_bc = 0;
    m_mc = 0;
  endtask
  task automatic check_outputs();
    chk("resolve_valid", resolve_valid_out, m_rv);
    chk("taken", branch_taken_out, m_tk);
    chk("mispredict", mispredict_out, m_mp);
    chk("misaligned", misaligned_out, m_mis);
    chk("redirect", redirect_pc_out, m_redir);
    chk("link", link_addr_out, m_link);
    chk("branch_count", branch_count_out, m_bc % (64'd1 << 32));
    chk("mispredict_count", mispredict_count_out, m_mc % (64'd1 << 32));
    chk("branch_count4", bc4, m_bc % 16);
    chk("mispredict_count4", mc4, m_mc % 16);
  endtask
  task automatic apply(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] pc, rs1, rs2, imm,
                       input bit pred, v, fl, input logic [31:0] fpc);
    bit t, taken, mis, mp;
    logic [31:0] tgt;
    opcode_6_to_2_in = op; funct3_in = f3; pc_in = pc; rs1_in = rs1; rs2_in = rs2; imm_in = imm;
    predicted_taken_in = pred; valid_in = v; flush_in = fl; fetch_pc_in = fpc;
    #1;
    chk("predict", predict_taken_out, bht[(fpc >> 2) % 64] >= 2);
    m_rv = v && !fl && (op == JAL || op == JALR || op == BR);
    if (m_rv) begin
      case (f3)
        3'd0: t = rs1 == rs2;
        3'd1: t = rs1 != rs2;
        3'd4: t = $signed(rs1) < $signed(rs2);
        3'd5: t = $signed(rs1) >= $signed(rs2);
        3'd6: t = rs1 < rs2;
        3'd7: t = rs1 >= rs2;
        default: t = 0;
      endcase
      tgt = op == JALR ? (rs1 + imm) & 32'hFFFF_FFFE : pc + imm;
      taken = op == BR ? t : 1;
      mis = taken && tgt[1];
      mp = !mis && (op == JALR || (op == JAL && !pred) || (op == BR && pred != taken));
      m_tk = taken; m_mp = mp; m_mis = mis;
      m_redir = taken ? tgt : pc + 4;
      m_link = pc + 4;
      m_bc++;
      if (mp) m_mc++;
      if (op == BR && !mis) begin
        int k = (pc >> 2) % 64;
        bht[k] = taken ? (bht[k] == 3 ? 3 : bht[k] + 1) : (bht[k] == 0 ? 0 : bht[k] - 1);
      end
    end
    @(posedge clk_in);
    #1;
    check_outputs();
  endtask
  typedef struct {
    logic [4:0] op; logic [2:0] f3; logic [31:0] pc, rs1, rs2, imm; bit pred;
    bit tk, mp, mis; logic [31:0] redir;
  } vec_t;
  vec_t vt[12];
  initial begin
    longint bc_save, mc_save;
    vt[0]  = '{BR,   3'd0, 32'h100, 32'h5,        32'h5,        32'h20,       0, 1, 1, 0, 32'h120};
    vt[1]  = '{BR,   3'd4, 32'h200, 32'hFFFFFFFF, 32'h1,        32'h10,       0, 1, 1, 0, 32'h210};
    vt[2]  = '{BR,   3'd6, 32'h204, 32'hFFFFFFFF, 32'h1,        32'h10,       0, 0, 0, 0, 32'h208};
    vt[3]  = '{BR,   3'd5, 32'h208, 32'h7,        32'h7,        32'hFFFFFFF8, 1, 1, 0, 0, 32'h200};
    vt[4]  = '{JALR, 3'd0, 32'h300, 32'h1003,     32'h0,        32'h0,        0, 1, 0, 1, 32'h1002};
    vt[5]  = '{JAL,  3'd0, 32'h400, 32'h0,        32'h0,        32'h40,       1, 1, 0, 0, 32'h440};
    vt[6]  = '{JAL,  3'd0, 32'h404, 32'h0,        32'h0,        32'h100,      0, 1, 1, 0, 32'h504};
    vt[7]  = '{JALR, 3'd0, 32'h408, 32'h2001,     32'h0,        32'h3,        1, 1, 1, 0, 32'h2004};
    vt[8]  = '{BR,   3'd1, 32'h500, 32'h1,        32'h2,        32'h100,      1, 1, 0, 0, 32'h600};
    vt[9]  = '{BR,   3'd2, 32'h504, 32'h1,        32'h1,        32'h100,      1, 0, 1, 0, 32'h508};
    vt[10] = '{BR,   3'd7, 32'h600, 32'h1,        32'hFFFFFFFF, 32'h100,      0, 0, 0, 0, 32'h604};
    vt[11] = '{BR,   3'd0, 32'h700, 32'h0,        32'h0,        32'h22,       0, 1, 0, 1, 32'h722};
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_outputs();
    chk("reset_predict", predict_taken_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply(vt[i].op, vt[i].f3, vt[i].pc, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].pred, 1, 0, vt[i].pc);
      chk($sformatf("vec%0d_valid", i), resolve_valid_out, 1);
      chk($sformatf("vec%0d_taken", i), branch_taken_out, vt[i].tk);
      chk($sformatf("vec%0d_mp", i), mispredict_out, vt[i].mp);
      chk($sformatf("vec%0d_mis", i), misaligned_out, vt[i].mis);
      chk($sformatf("vec%0d_redir", i), redirect_pc_out, vt[i].redir);
      chk($sformatf("vec%0d_link", i), link_addr_out, vt[i].pc + 32'd4);
      if (i == 0) begin
        fetch_pc_in = 32'h100;
        #1;
        chk("bht0_after_beq", predict_taken_out, 1);
      end
    end
    for (int i = 0; i < 4; i++) apply(BR, 3'd0, 32'h810, 32'h9, 32'h9, 32'h40, i > 1, 1, 0, 32'h810);
    chk("sat_predict", predict_taken_out, 1);
    apply(BR, 3'd0, 32'h810, 32'h9, 32'h8, 32'h40, 1, 1, 0, 32'h810);
    chk("after_nt_predict", predict_taken_out, 1);
    apply(BR, 3'd0, 32'h810, 32'h9, 32'h9, 32'h40, 1, 1, 0, 32'h810);
    rst_n_in = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("mid_reset_predict", predict_taken_out, 0);
    fetch_pc_in = 32'h100;
    #1;
    chk("mid_reset_bht0", predict_taken_out, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 16; i++) apply(BR, 3'd1, 32'h40 + 32'(i * 4), 32'h1, 32'h2, 32'h8, 1, 1, 0, 32'h40);
    chk("wrap_count4", bc4, 0);
    chk("count32_16", branch_count_out, 16);
    bc_save = m_bc;
    mc_save = m_mc;
    apply(JALR, 3'd0, 32'h900, 32'h1000, 32'h0, 32'h0, 0, 1, 1, 32'h900);
    chk("flush_no_valid", resolve_valid_out, 0);
    apply(5'b01100, 3'd0, 32'h904, 32'h1, 32'h1, 32'h0, 0, 1, 0, 32'h904);
    chk("nonbranch_no_valid", resolve_valid_out, 0);
    chk("flush_count", branch_count_out, bc_save);
    chk("flush_mcount", mispredict_count_out, mc_save);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      logic [31:0] a, b, imm, pc;
      case ($urandom_range(0, 4))
        0: op = JAL;
        1: op = JALR;
        2, 3: op = BR;
        default: op = 5'($urandom);
      endcase
      a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
      b = $urandom_range(0, 2) == 0 ? a : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1);
      imm = $urandom_range(0, 5) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
      pc = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      apply(op, 3'($urandom), pc, a, b, imm, 1'($urandom), $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 1) ? pc : 32'h1000 + 32'($urandom_range(0, 15) * 4));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch resolution stage with an integrated bimodal predictor, the successor to the combinational branch decision logic in the RV32I execute stage. It evaluates JAL/JALR/conditional branches, computes targets and link addresses, and compares the outcome against the fetch-stage prediction. It registers a redirect/mispredict result one cycle later and trains a table of 2-bit saturating counters that fetch reads every cycle. Performance counters track resolved branches and mispredicts.

## Interface
- XLEN, 32, datapath width (32 or 64)
- BHT_ENTRIES, 64, predictor entries; power of two, 4..1024
- CNT_W, 32, width of performance counters
- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- fetch_pc_in  in  XLEN  fetch PC for prediction lookup
- predict_taken_out  out  1  combinational: MSB of BHT[fetch_pc_in[IDX+1:2]], IDX=log2(BHT_ENTRIES)
- valid_in  in  1  instruction present in execute this cycle
- flush_in  in  1  kill the instruction in execute and any pending result
- pc_in, rs1_in, rs2_in, imm_in  in  XLEN  PC, operands, sign-extended immediate
- opcode_6_to_2_in  in  5  JAL=11011, JALR=11001, Branch=11000
- funct3_in  in  3  branch condition
- predicted_taken_in  in  1  prediction carried down from fetch for this instruction
- resolve_valid_out  out  1  registered result valid
- branch_taken_out  out  1  registered actual outcome
- mispredict_out  out  1  registered; fetch must redirect to redirect_pc_out
- redirect_pc_out  out  XLEN  correct next PC
- link_addr_out  out  XLEN  pc_in+4 for rd writeback (JAL/JALR)
- misaligned_out  out  1  taken target not 4-byte aligned
- branch_count_out, mispredict_count_out  out  CNT_W  wrapping event counters

## Operation
- Accept when valid_in=1, flush_in=0, and opcode is JAL, JALR, or Branch. Other opcodes produce no result, no BHT update, and no count.
- Conditions: 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU. Funct3 010/011 are not taken. All comparisons are XLEN-wide.
- Targets are computed modulo 2^XLEN, with carries dropped. JAL/Branch: pc_in+imm_in. JALR: (rs1_in+imm_in) with bit0 cleared.
- Taken: JAL and JALR always taken; Branch taken per condition.
- Mispredict:
  - Branch: predicted_taken_in != taken.
  - JAL: predicted_taken_in=0.
  - JALR: always mispredicts, because fetch has no target.
- redirect_pc_out = taken ? target : pc_in+4.
- Misaligned: taken and target[1]=1. When set, misaligned_out=1, mispredict_out=0, no BHT update. The instruction is still counted in branch_count_out.
- BHT: 2-bit counters, reset to 01 (weakly not-taken). Only accepted, aligned Branch-opcode instructions update, using index pc_in[IDX+1:2].
  - Taken: counter+1, saturating at 11.
  - Not taken: counter-1, saturating at 00.
- BHT read/write collision at the same index in the same cycle: predict_taken_out returns the pre-update value (read-before-write).
- Counters: branch_count_out +1 per accepted instruction; mispredict_count_out +1 per mispredict_out=1. Both wrap at 2^CNT_W.

## Timing
- Latency 1: an instruction accepted at edge N drives its result on outputs after edge N, valid for exactly one cycle. Throughput is one per cycle.
- resolve_valid_out is 0 in cycles with no accepted instruction. Other result outputs hold their last value but are meaningful only with resolve_valid_out=1.
- BHT update and counter increments occur on the same edge that registers the result.
- flush_in=1 with valid_in=1: flush wins. No result, no BHT update, no count.
- Reset (async assert, any time): all outputs and counters 0, all BHT entries 01, predict_taken_out=0. A result in flight is lost. The first accept is allowed on the first edge after rst_n_in rises.

## Test plan
- BEQ rs1=rs2=5, pc=0x100, imm=0x20, predicted 0 -> next cycle: resolve_valid=1, taken=1, mispredict=1, redirect=0x120; BHT[0] goes 01->10.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken. BLTU with the same operands -> not taken, redirect=pc+4. BGE with rs1=rs2 -> taken.
- JALR rs1=0x1003, imm=0 -> target 0x1002 is misaligned: misaligned=1, mispredict=0, link=pc+4, no BHT change.
- Same-PC branch taken 4 times -> counter saturates at 11 and predict_taken_out=1. Then 1 not-taken -> counter 10, prediction stays 1.
- valid_in with flush_in=1 -> resolve_valid_out=0, counters unchanged. Reset asserted mid-stream -> outputs 0 immediately, BHT entries read 01.
- Preload branch_count to 2^CNT_W-1 (small CNT_W=4), resolve 1 branch -> counter wraps to 0.
